song_reader: RTL and testbench

- Sequences one song's notes out of the song ROM and into the note player.
- Sits between the transport controller (play, song select, reset_play, song_done) and the note-player datapath.
- Walks a per-song note index, issues ROM reads, and presents each note/duration with a one-cycle new_note strobe.
- Waits for note_done before fetching the next note, and reports song completion back to the controller.

---
 rtl/music_pkg.sv | 17 +
 rtl/note_index_counter.sv | 19 +
 rtl/song_reader.sv | 124 ++++++++++++
 tb/tb_song_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared encodings and default widths for the song sequencing blocks.
package music_pkg;
   localparam int SONG_BITS      = 2;
   localparam int NOTE_ADDR_BITS = 5;
   localparam int NOTE_BITS      = 6;
   localparam int DUR_BITS       = 6;

   // A zero duration marks the end of a song in ROM.
   localparam int END_MARKER = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } state_t;
endpackage

// File: rtl/note_index_counter.sv
// Per-song note index: enable-driven up counter with sync clear and terminal count.
module note_index_counter #(
   parameter int W = music_pkg::NOTE_ADDR_BITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] idx,
   output logic         tc
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     idx <= '0;
      else if (clear) idx <= '0;
      else if (en)    idx <= idx + W'(1);
   end

   assign tc = &idx;
endmodule

// File: rtl/song_reader.sv
// Walks one song's notes out of ROM, strobing each note to the player and
// reporting end of song to the transport controller.
module song_reader #(
   parameter int SONG_BITS      = music_pkg::SONG_BITS,
   parameter int NOTE_ADDR_BITS = music_pkg::NOTE_ADDR_BITS,
   parameter int NOTE_BITS      = music_pkg::NOTE_BITS,
   parameter int DUR_BITS       = music_pkg::DUR_BITS,
   parameter int ROM_LATENCY    = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              play,
   input  logic                              reset_play,
   input  logic [SONG_BITS-1:0]              song,
   input  logic                              note_done,
   output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
   input  logic [NOTE_BITS+DUR_BITS-1:0]     rom_data,
   output logic [NOTE_BITS-1:0]              note,
   output logic [DUR_BITS-1:0]               duration,
   output logic                              new_note,
   output logic                              song_done
);
   import music_pkg::*;

   localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

   state_t                    state, state_nxt;
   logic [LAT_W-1:0]          lat_cnt, lat_nxt;
   logic [NOTE_ADDR_BITS-1:0] idx;
   logic                      idx_tc, idx_en, load, nn_nxt, sd_nxt;
   logic [NOTE_BITS-1:0]      rom_note;
   logic [DUR_BITS-1:0]       rom_dur;
   logic                      fetch_last, is_end;

   note_index_counter #(.W(NOTE_ADDR_BITS)) u_idx (
      .clk   (clk),
      .reset (reset),
      .clear (reset_play),
      .en    (idx_en),
      .idx   (idx),
      .tc    (idx_tc)
   );

   assign rom_addr   = {song, idx};
   assign rom_note   = rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
   assign rom_dur    = rom_data[DUR_BITS-1:0];
   assign fetch_last = (lat_cnt == LAT_W'(ROM_LATENCY-1));
   assign is_end     = (rom_dur == DUR_BITS'(END_MARKER));

   always_comb begin
      state_nxt = state;
      lat_nxt   = lat_cnt;
      idx_en    = 1'b0;
      load      = 1'b0;
      nn_nxt    = 1'b0;
      sd_nxt    = 1'b0;
      if (reset_play) begin
         // Restart overrides any coincident note_done or end marker.
         state_nxt = IDLE;
         lat_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (play) begin
                  state_nxt = FETCH;
                  lat_nxt   = '0;
               end
            end
            FETCH: begin
               lat_nxt = lat_cnt + LAT_W'(1);
               if (fetch_last) begin
                  lat_nxt = '0;
                  if (is_end) begin
                     sd_nxt    = 1'b1;
                     state_nxt = DONE;
                  end else begin
                     load      = 1'b1;
                     nn_nxt    = 1'b1;
                     state_nxt = WAIT;
                  end
               end
            end
            WAIT: begin
               if (note_done) begin
                  // The last slot always ends the song instead of wrapping.
                  if (idx_tc) begin
                     sd_nxt    = 1'b1;
                     state_nxt = DONE;
                  end else begin
                     idx_en    = 1'b1;
                     lat_nxt   = '0;
                     state_nxt = play ? FETCH : IDLE;
                  end
               end
            end
            DONE: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         note      <= '0;
         duration  <= '0;
         new_note  <= 1'b0;
         song_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_nxt;
         new_note  <= nn_nxt;
         song_done <= sd_nxt;
         if (reset_play) begin
            note     <= '0;
            duration <= '0;
         end else if (load) begin
            note     <= rom_note;
            duration <= rom_dur;
         end
      end
   end
endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: expected note/end events come from the ROM contents.
module tb_song_reader;
   logic       clk = 0, reset = 0, play = 0, reset_play = 0, note_done = 0;
   logic [1:0] song = 0;
   logic [6:0] rom_addr;
   logic [11:0] rom_data;
   logic [5:0] note, duration;
   logic       new_note, song_done;

   logic       play3 = 0, note_done3 = 0;
   logic [1:0] song3 = 2'd3;
   logic [6:0] rom_addr3;
   logic [11:0] rom_data3, r1, r2;
   logic [5:0] note3, duration3;
   logic       new_note3, song_done3;

   logic [11:0] mem [128];

   typedef struct packed {logic sd; logic [5:0] n; logic [5:0] d;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   int   nchk = 0, nerr = 0, ev_cnt = 0;
   logic last_sd = 0;

   always #5 clk = ~clk;

   assign rom_data = mem[rom_addr];
   always @(posedge clk) begin
      r1 <= mem[rom_addr3];
      r2 <= r1;
   end
   assign rom_data3 = r2;

   song_reader u_dut (
      .clk(clk), .reset(reset), .play(play), .reset_play(reset_play), .song(song),
      .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
      .duration(duration), .new_note(new_note), .song_done(song_done));

   song_reader #(.ROM_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .play(play3), .reset_play(reset_play), .song(song3),
      .note_done(note_done3), .rom_addr(rom_addr3), .rom_data(rom_data3), .note(note3),
      .duration(duration3), .new_note(new_note3), .song_done(song_done3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: a song is its notes in order until a zero duration or the 32nd slot.
   function automatic void push_song(input int s);
      logic [11:0] w;
      for (int i = 0; i < 32; i++) begin
         w = mem[s*32+i];
         if (w[5:0] == 6'd0) begin
            exp_q.push_back('{sd: 1'b1, n: 6'd0, d: 6'd0});
            return;
         end
         exp_q.push_back('{sd: 1'b0, n: w[11:6], d: w[5:0]});
      end
      exp_q.push_back('{sd: 1'b1, n: 6'd0, d: 6'd0});
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (new_note && song_done) begin
            nchk++; nerr++;
            $display("FAIL exclusive: new_note and song_done both high");
         end
         if (new_note || song_done) begin
            ev_cnt++;
            last_sd = song_done;
            if (exp_q.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL unexpected_event: new_note=%0b song_done=%0b note=%0d dur=%0d",
                        new_note, song_done, note, duration);
            end else begin
               e = exp_q.pop_front();
               check("event", {19'd0, song_done, new_note ? note : 6'd0, new_note ? duration : 6'd0},
                     {19'd0, e.sd, e.sd ? 6'd0 : e.n, e.sd ? 6'd0 : e.d});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      note_done = 1; tick(1); note_done = 0;
   endtask

   task automatic wait_event(input int start, output bit ok);
      ok = (ev_cnt != start);
      for (int i = 0; i < 60 && !ok; i++) begin
         tick(1);
         if (ev_cnt != start) ok = 1;
      end
      if (!ok) begin
         nchk++; nerr++;
         $display("FAIL wait_event: no event within 60 cycles got 0 expected 1");
      end
   endtask

   task automatic restart();
      reset_play = 1; play = 0; tick(1); reset_play = 0;
   endtask

   task automatic run_song(input int s, input bit pauses);
      int c; bit ok;
      restart();
      song = 2'(s);
      push_song(s);
      c = ev_cnt;
      play = 1;
      for (int k = 0; k < 40; k++) begin
         wait_event(c, ok);
         if (!ok || last_sd) break;
         tick($urandom_range(0, 3));
         c = ev_cnt;
         if (pauses && $urandom_range(0, 2) == 0) begin
            play = 0;
            pulse_done();
            tick($urandom_range(1, 4));
            play = 1;
         end else pulse_done();
      end
      tick(4);
      play = 0;
   endtask

   task automatic fill_song(input int s, input bit marker);
      for (int i = 0; i < 32; i++)
         mem[s*32+i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
      if (marker) mem[s*32 + $urandom_range(0, 31)][5:0] = 6'd0;
   endtask

   initial begin
      int c; bit ok;
      for (int s = 0; s < 4; s++) fill_song(s, s != 3);
      mem[32] = {6'd10, 6'd4};
      mem[33] = {6'd20, 6'd8};
      mem[34] = 12'd0;

      // Reset state
      tick(3);
      check("reset_outs", {18'd0, new_note, song_done, note, duration}, 32'd0);
      check("reset_addr", rom_addr, 7'h00);
      reset = 1; tick(1);

      // Basic fetch with exact timing
      song = 2'd1; push_song(1); play = 1;
      tick(1);
      check("basic_addr0", rom_addr, 7'h20);
      check("basic_nn_early", new_note, 0);
      tick(1);
      check("basic_note0", {new_note, note, duration}, {1'b1, 6'd10, 6'd4});
      note_done = 1; tick(1); note_done = 0;
      check("basic_addr1", rom_addr, 7'h21);
      check("basic_nn_width", new_note, 0);
      tick(1);
      check("basic_note1", {new_note, note, duration}, {1'b1, 6'd20, 6'd8});
      note_done = 1; tick(1); note_done = 0;
      check("basic_addr2", rom_addr, 7'h22);
      tick(1);
      check("basic_done", {song_done, new_note}, 2'b10);
      tick(4);
      check("basic_hold", {song_done, new_note, note, duration}, {2'b00, 6'd20, 6'd8});
      check("basic_hold_addr", rom_addr, 7'h22);

      // reset_play coincident with note_done while waiting on the second note
      restart();
      exp_q.push_back('{sd: 1'b0, n: 6'd10, d: 6'd4});
      exp_q.push_back('{sd: 1'b0, n: 6'd20, d: 6'd8});
      c = ev_cnt; play = 1;
      wait_event(c, ok);
      c = ev_cnt; pulse_done();
      wait_event(c, ok);
      reset_play = 1; note_done = 1; play = 0;
      tick(1);
      reset_play = 0; note_done = 0;
      check("rp_outs", {18'd0, new_note, song_done, note, duration}, 32'd0);
      check("rp_addr", rom_addr, 7'h20);
      tick(4);

      // Random songs, one with no end marker, with pauses
      for (int s = 0; s < 3; s++) fill_song(s, 1);
      run_song(3, 1);
      check("full_addr", rom_addr, 7'h7f);
      for (int k = 0; k < 6; k++) run_song($urandom_range(0, 3), $urandom_range(0, 1));

      // Async reset between edges while fetching slot 1
      restart();
      song = 2'd3;
      exp_q.push_back('{sd: 1'b0, n: mem[96][11:6], d: mem[96][5:0]});
      c = ev_cnt; play = 1;
      wait_event(c, ok);
      pulse_done();
      #2 reset = 0; play = 0;
      #1;
      check("areset_outs", {18'd0, new_note, song_done, note, duration}, 32'd0);
      check("areset_addr", rom_addr, 7'h60);
      tick(1);
      reset = 1;
      exp_q.push_back('{sd: 1'b0, n: mem[96][11:6], d: mem[96][5:0]});
      c = ev_cnt; play = 1;
      wait_event(c, ok);
      restart();

      // Three-cycle ROM: new_note after the fourth edge from play
      play3 = 1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("lat3_nn", new_note3, 0);
         check("lat3_addr", rom_addr3, 7'h60);
      end
      tick(1);
      check("lat3_note", {new_note3, note3, duration3}, {1'b1, mem[96]});
      play3 = 0;
      tick(2);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
